// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a 640x480@60 VGA output.
//   Divides clk_i into a one-clock pixel strobe. On each strobe it presents the next
//   pixel coordinate, the visible flag, line/frame start pulses and a completed-frame
//   count. hsync/vsync pass through a strobe-clocked delay line so they line up with
//   the text pipeline's RGB output.
// Ports:
//   clk_i           system clock
//   rst_i           synchronous reset, active-high
//   pix_en_o        one-clk pixel strobe (registered)
//   x_ord_o         current column 0..H_TOTAL-1, blanking included
//   y_ord_o         current line 0..V_TOTAL-1
//   visible_o       1 inside the active area
//   hsync_o         horizontal sync, H_POL when active, lagged SYNC_DLY strobes
//   vsync_o         vertical sync, V_POL when active, lagged SYNC_DLY strobes
//   line_start_o    one-clk pulse on the strobe presenting x_ord_o = 0
//   frame_start_o   one-clk pulse on the strobe presenting (0,0)
//   frame_count_o   completed frames, wraps 255 -> 0
// Latency: a coordinate appears on the same edge that raises pix_en_o.
// Flow control: none; the raster free-runs and only rst_i restarts it.

module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int SYNC_DLY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pix_en_o,
  output logic [9:0] x_ord_o,
  output logic [9:0] y_ord_o,
  output logic       visible_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       line_start_o,
  output logic       frame_start_o,
  output logic [7:0] frame_count_o
);

  // Raster boundaries, all resolved at elaboration.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

  // Inactive sync level, used for reset of the whole delay line.
  localparam logic [SYNC_DLY:0] HS_IDLE = {(SYNC_DLY + 1){~H_POL}};
  localparam logic [SYNC_DLY:0] VS_IDLE = {(SYNC_DLY + 1){~V_POL}};

  // Clock divider and the strobe it produces.
  logic [1:0] div_q, div_d;
  logic       strobe;

  // Internal raster position (the pixel about to be presented).
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Presented outputs.
  logic       pix_en_q, pix_en_d;
  logic [9:0] x_ord_q, x_ord_d;
  logic [9:0] y_ord_q, y_ord_d;
  logic       visible_q, visible_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Set by the first strobe after reset so the opening (0,0) is not counted
  // as a completed frame.
  logic       started_q, started_d;

  // Sync delay lines at output level. Stage 0 holds the raw sync for the pixel
  // just presented; stage SYNC_DLY drives the pin.
  logic [SYNC_DLY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DLY:0] vs_pipe_q, vs_pipe_d;

  logic hs_raw;
  logic vs_raw;

  // The strobe condition is decoded from the divider and registered into
  // pix_en_q on the same edge that loads the coordinate, so pix_en_o and the
  // new coordinate appear together.
  assign strobe = (div_q == DIV_LAST);

  assign hs_raw = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END)) ? H_POL : ~H_POL;
  assign vs_raw = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END)) ? V_POL : ~V_POL;

  always_comb begin
    div_d         = div_q + 2'd1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pix_en_d      = strobe;
    x_ord_d       = x_ord_q;
    y_ord_d       = y_ord_q;
    visible_d     = visible_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    started_d     = started_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;

    if (strobe) begin
      div_d = 2'd0;

      // Present the current position.
      x_ord_d       = h_cnt_q;
      y_ord_d       = v_cnt_q;
      visible_d     = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      started_d     = 1'b1;

      // Every (0,0) after the first one closes a frame.
      if (frame_start_d && started_q) begin
        frame_count_d = frame_count_q + 8'd1;
      end

      // Shift the sync delay lines by one pixel.
      hs_pipe_d[0] = hs_raw;
      vs_pipe_d[0] = vs_raw;
      for (int i = 1; i <= SYNC_DLY; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
      end

      // Advance the raster.
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q         <= 2'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      pix_en_q      <= 1'b0;
      x_ord_q       <= 10'd0;
      y_ord_q       <= 10'd0;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      started_q     <= 1'b0;
      hs_pipe_q     <= HS_IDLE;
      vs_pipe_q     <= VS_IDLE;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_en_q      <= pix_en_d;
      x_ord_q       <= x_ord_d;
      y_ord_q       <= y_ord_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      started_q     <= started_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign pix_en_o      = pix_en_q;
  assign x_ord_o       = x_ord_q;
  assign y_ord_o       = y_ord_q;
  assign visible_o     = visible_q;
  assign hsync_o       = hs_pipe_q[SYNC_DLY];
  assign vsync_o       = vs_pipe_q[SYNC_DLY];
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken raster so that full frames
// and a frame-counter wrap fit in a short run. The expected output of every clock
// edge is derived from the pixel index since reset and pushed into a queue; a
// monitor on the falling edge pops and compares against the DUT.

module tb_vga_sync_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 6;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit H_POL    = 1'b0;
  localparam bit V_POL    = 1'b1;
  localparam int SYNC_DLY = 2;

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en;
  logic [9:0] x_ord;
  logic [9:0] y_ord;
  logic       visible;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL   (H_POL),    .V_POL(V_POL), .SYNC_DLY(SYNC_DLY)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pix_en_o     (pix_en),
    .x_ord_o      (x_ord),
    .y_ord_o      (y_ord),
    .visible_o    (visible),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .line_start_o (line_start),
    .frame_start_o(frame_start),
    .frame_count_o(frame_count)
  );

  typedef struct packed {
    logic       pix;
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: clocks since reset release and strobes presented.
  int   clk_since_rel = 0;
  int   pix_idx       = 0;
  obs_t held;

  // Everything presented by the strobe that shows pixel number p since reset.
  function automatic obs_t pixel_at(input int p);
    obs_t e;
    int   x, y, q;
    bit   hs_act, vs_act;
    x = p % HT;
    y = (p / HT) % VT;
    // Syncs shown now belong to the pixel SYNC_DLY strobes earlier.
    q = p - SYNC_DLY;
    hs_act = (q >= 0) && ((q % HT) >= H_ACTIVE + H_FP) && ((q % HT) < H_ACTIVE + H_FP + H_SYNC);
    vs_act = (q >= 0) && (((q / HT) % VT) >= V_ACTIVE + V_FP) &&
             (((q / HT) % VT) < V_ACTIVE + V_FP + V_SYNC);
    e.pix = 1'b1;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vis = (x < H_ACTIVE) && (y < V_ACTIVE);
    e.hs  = hs_act ? H_POL : ~H_POL;
    e.vs  = vs_act ? V_POL : ~V_POL;
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    e.fc  = 8'((p / FRAME) % 256);
    return e;
  endfunction

  // Predict the outputs after the next rising edge given the reset level there.
  task automatic plan_edge(input logic r);
    obs_t e;
    if (r) begin
      e = '{pix: 1'b0, x: 10'd0, y: 10'd0, vis: 1'b0, hs: ~H_POL, vs: ~V_POL,
            ls: 1'b0, fs: 1'b0, fc: 8'd0};
      clk_since_rel = 0;
      pix_idx       = 0;
      held          = e;
    end else begin
      clk_since_rel++;
      if (clk_since_rel % CLK_DIV == 0) begin
        e = pixel_at(pix_idx);
        pix_idx++;
        held = e;
      end else begin
        e     = held;
        e.pix = 1'b0;
        e.ls  = 1'b0;
        e.fs  = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Hold rst at level r for n edges.
  task automatic drive(input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      plan_edge(r);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one expected record per rising edge, compared mid-cycle.
  obs_t act;
  obs_t want;
  logic [7:0] prev_fc = 8'd0;
  bit   wrap_seen = 1'b0;

  always @(negedge clk) begin
    act = '{pix: pix_en, x: x_ord, y: y_ord, vis: visible, hs: hsync, vs: vsync,
            ls: line_start, fs: frame_start, fc: frame_count};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL no_expectation t=%0t: DUT shows pix=%0b x=%0d y=%0d", $time, act.pix, act.x, act.y);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        errors++;
        $display("FAIL raster t=%0t got pix=%0b x=%0d y=%0d vis=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d want pix=%0b x=%0d y=%0d vis=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                 $time, act.pix, act.x, act.y, act.vis, act.hs, act.vs, act.ls, act.fs, act.fc,
                 want.pix, want.x, want.y, want.vis, want.hs, want.vs, want.ls, want.fs, want.fc);
      end
    end
    if (prev_fc == 8'd255 && act.fc == 8'd0 && act.fs === 1'b1 && act.pix === 1'b1) begin
      wrap_seen = 1'b1;
    end
    prev_fc = act.fc;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset held three clocks, then a couple of frames.
    drive(1'b1, 3);
    drive(1'b0, 2 * FRAME * CLK_DIV + 37);

    // Single-clock resets landing at random raster positions.
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1);
      drive(1'b0, int'($urandom_range(20, 450)));
    end

    // Long run through 257 frames to take frame_count across 255 -> 0.
    drive(1'b1, 2);
    drive(1'b0, 257 * FRAME * CLK_DIV + 60);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records never compared, required 0", exp_q.size());
    end
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL fc_wrap: frame_count 255->0 on frame_start seen=%0b, required 1", wrap_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
